// File: rtl/fifo36_arb4_pkg.sv
// Shared fifo36 line layout and merge-arbiter state encoding.
package fifo36_arb4_pkg;

    localparam int unsigned FIFO36_EOF = 33;

    // Line layout: [35:34] occ, [33] EOF, [32] SOF, [31:0] data.
    typedef struct packed {
        logic [1:0]  occ;
        logic        eof;
        logic        sof;
        logic [31:0] data;
    } fifo36_line_t;

    localparam logic ARB_IDLE = 1'b0;
    localparam logic ARB_PKT  = 1'b1;

    typedef enum logic {
        StIdle = ARB_IDLE,
        StPkt  = ARB_PKT
    } arb_state_e;

endpackage

// File: rtl/arb_pick4.sv
// 4-way requester pick: round-robin after 'last', or fixed priority with port 0 highest.
module arb_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] last,
    input  logic       prio,
    output logic [1:0] idx,
    output logic       any
);

    logic [1:0] cand;

    always_comb begin
        idx  = '0;
        any  = |req;
        cand = '0;
        if (prio) begin
            for (int i = 3; i >= 0; i--) begin
                if (req[i]) idx = 2'(i);
            end
        end else begin
            // Scan from farthest to nearest so the first requester after 'last' wins.
            for (int k = 4; k >= 1; k--) begin
                cand = last + 2'(k);
                if (req[cand]) idx = cand;
            end
        end
    end

endmodule

// File: rtl/fifo36_arb4.sv
// Packet-atomic merge of four fifo36 streams onto one output, one packet per grant.
module fifo36_arb4
    import fifo36_arb4_pkg::*;
#(
    parameter int unsigned PRIO    = 0,
    parameter int unsigned EOF_BIT = FIFO36_EOF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic [3:0]  port_en,
    input  logic [35:0] data0_i,
    input  logic        src0_rdy_i,
    output logic        dst0_rdy_o,
    input  logic [35:0] data1_i,
    input  logic        src1_rdy_i,
    output logic        dst1_rdy_o,
    input  logic [35:0] data2_i,
    input  logic        src2_rdy_i,
    output logic        dst2_rdy_o,
    input  logic [35:0] data3_i,
    input  logic        src3_rdy_i,
    output logic        dst3_rdy_o,
    output logic [35:0] data_o,
    output logic        src_rdy_o,
    input  logic        dst_rdy_i,
    output logic [1:0]  grant_o,
    output logic        busy_o
);

    logic [35:0] data_in [4];
    logic [3:0]  src_rdy_in;
    logic [3:0]  dst_rdy_out;
    arb_state_e  state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic [1:0]  last_q, last_d;
    logic [1:0]  pick_idx;
    logic        pick_any;
    logic        xfer;
    logic        line_eof;

    assign data_in[0] = data0_i;
    assign data_in[1] = data1_i;
    assign data_in[2] = data2_i;
    assign data_in[3] = data3_i;
    assign src_rdy_in = {src3_rdy_i, src2_rdy_i, src1_rdy_i, src0_rdy_i};

    assign dst0_rdy_o = dst_rdy_out[0];
    assign dst1_rdy_o = dst_rdy_out[1];
    assign dst2_rdy_o = dst_rdy_out[2];
    assign dst3_rdy_o = dst_rdy_out[3];

    arb_pick4 u_pick (
        .req  (src_rdy_in & port_en),
        .last (last_q),
        .prio (PRIO != 0),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    assign data_o   = data_in[grant_q];
    assign line_eof = data_in[grant_q][EOF_BIT];
    assign grant_o  = grant_q;
    assign busy_o   = (state_q == StPkt);

    always_comb begin
        src_rdy_o   = 1'b0;
        dst_rdy_out = '0;
        xfer        = 1'b0;
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        unique case (state_q)
            StIdle: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    state_d = StPkt;
                end
            end
            StPkt: begin
                src_rdy_o            = src_rdy_in[grant_q];
                dst_rdy_out[grant_q] = dst_rdy_i;
                xfer                 = src_rdy_in[grant_q] & dst_rdy_i;
                if (xfer && line_eof) begin
                    last_d  = grant_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // last resets to 3 so round-robin serves port 0 first.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_q <= StIdle;
            grant_q <= 2'd0;
            last_q  <= 2'd3;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_fifo36_arb4.sv
// Bench for fifo36_arb4: vector table, directed packet sequences, random traffic vs a model.
module tb_fifo36_arb4;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic [3:0]  port_en;
    logic [35:0] din [4];
    logic [3:0]  srdy;
    logic        dst_rdy;

    logic [35:0] dout [2];
    logic        sro  [2];
    logic [3:0]  dro  [2];
    logic [1:0]  gnt  [2];
    logic        bsy  [2];

    always #5 clk = ~clk;

    fifo36_arb4 #(.PRIO(0), .EOF_BIT(33)) u_dut_rr (
        .clk(clk), .reset(reset), .clear(clear), .port_en(port_en),
        .data0_i(din[0]), .src0_rdy_i(srdy[0]), .dst0_rdy_o(dro[0][0]),
        .data1_i(din[1]), .src1_rdy_i(srdy[1]), .dst1_rdy_o(dro[0][1]),
        .data2_i(din[2]), .src2_rdy_i(srdy[2]), .dst2_rdy_o(dro[0][2]),
        .data3_i(din[3]), .src3_rdy_i(srdy[3]), .dst3_rdy_o(dro[0][3]),
        .data_o(dout[0]), .src_rdy_o(sro[0]), .dst_rdy_i(dst_rdy),
        .grant_o(gnt[0]), .busy_o(bsy[0])
    );

    fifo36_arb4 #(.PRIO(1), .EOF_BIT(33)) u_dut_fp (
        .clk(clk), .reset(reset), .clear(clear), .port_en(port_en),
        .data0_i(din[0]), .src0_rdy_i(srdy[0]), .dst0_rdy_o(dro[1][0]),
        .data1_i(din[1]), .src1_rdy_i(srdy[1]), .dst1_rdy_o(dro[1][1]),
        .data2_i(din[2]), .src2_rdy_i(srdy[2]), .dst2_rdy_o(dro[1][2]),
        .data3_i(din[3]), .src3_rdy_i(srdy[3]), .dst3_rdy_o(dro[1][3]),
        .data_o(dout[1]), .src_rdy_o(sro[1]), .dst_rdy_i(dst_rdy),
        .grant_o(gnt[1]), .busy_o(bsy[1])
    );

    int total = 0;
    int bad   = 0;

    // Reference model: one packet in flight per instance; instance k uses PRIO=k.
    logic       m_busy  [2];
    logic [1:0] m_grant [2];
    logic [1:0] m_last  [2];

    // Source generators
    int         pos [4];
    int         len [4];
    int         pkt [4];
    logic [3:0] gen_mask;
    int         gen_prob;
    int         len_fixed;
    int         len_max;
    int         src_inst;
    logic [3:0] acc;

    // Last observed output transfer of instance src_inst
    logic        o_fire;
    logic [35:0] o_line;
    logic [1:0]  o_gnt;

    typedef struct {
        logic       clr;
        logic [3:0] srdy;
        logic [3:0] eof;
        logic       dst;
        logic       busy;
        logic [1:0] grant;
        logic       sro;
        logic [3:0] dro;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] pick(input logic [3:0] req, input logic [1:0] last,
                                        input int prio);
        if (prio != 0) begin
            for (int i = 0; i < 4; i++) if (req[i]) return 2'(i);
        end else begin
            for (int off = 1; off <= 4; off++) begin
                int c;
                c = (int'(last) + off) % 4;
                if (req[c]) return 2'(c);
            end
        end
        return 2'd0;
    endfunction

    task automatic check_model(input int k);
        logic [3:0] exp_dro;
        logic       exp_sro;
        exp_sro = m_busy[k] && srdy[m_grant[k]];
        exp_dro = m_busy[k] ? (4'(dst_rdy) << m_grant[k]) : 4'b0000;
        chk($sformatf("busy%0d", k), 36'(bsy[k]), 36'(m_busy[k]));
        chk($sformatf("grant%0d", k), 36'(gnt[k]), 36'(m_grant[k]));
        chk($sformatf("src_rdy%0d", k), 36'(sro[k]), 36'(exp_sro));
        chk($sformatf("dst_rdy%0d", k), 36'(dro[k]), 36'(exp_dro));
        if (exp_sro) chk($sformatf("data%0d", k), dout[k], din[m_grant[k]]);
    endtask

    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            if (reset || clear) begin
                m_busy[k]  = 1'b0;
                m_grant[k] = 2'd0;
                m_last[k]  = 2'd3;
            end else if (!m_busy[k]) begin
                if ((srdy & port_en) != 4'b0000) begin
                    m_grant[k] = pick(srdy & port_en, m_last[k], k);
                    m_busy[k]  = 1'b1;
                end
            end else if (srdy[m_grant[k]] && dst_rdy && din[m_grant[k]][33]) begin
                m_last[k] = m_grant[k];
                m_busy[k] = 1'b0;
            end
        end
    endtask

    task automatic new_packet(input int p);
        pos[p] = 0;
        len[p] = (len_fixed > 0) ? len_fixed : int'($urandom_range(len_max, 1));
        pkt[p]++;
    endtask

    task automatic drive_src();
        for (int p = 0; p < 4; p++) begin
            din[p]  = {2'(pkt[p]), pos[p] == len[p] - 1, pos[p] == 0, 8'(p), 8'(pkt[p]),
                       16'(pos[p])};
            srdy[p] = gen_mask[p] && ($urandom_range(99) < gen_prob);
        end
    endtask

    task automatic gen_init();
        for (int p = 0; p < 4; p++) begin
            pkt[p] = 0;
            new_packet(p);
        end
        drive_src();
    endtask

    // One clock: check at negedge, update model at posedge, drive new inputs 1 time unit later.
    task automatic step(input bit do_check, input bit use_gen);
        @(negedge clk);
        if (do_check) begin
            check_model(0);
            check_model(1);
        end
        acc    = dro[src_inst] & srdy;
        o_fire = sro[src_inst] && dst_rdy;
        o_line = dout[src_inst];
        o_gnt  = gnt[src_inst];
        @(posedge clk);
        model_update();
        #1;
        if (use_gen) begin
            for (int p = 0; p < 4; p++) begin
                if (acc[p]) begin
                    if (pos[p] == len[p] - 1) new_packet(p);
                    else pos[p]++;
                end
            end
            drive_src();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear = 1'b0;
        step(1'b0, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        int nlines;
        int order [$];
        int seen;
        int p1_lines;
        bit p1_done;
        int regrant;

        reset     = 1'b1;
        clear     = 1'b0;
        port_en   = 4'hF;
        dst_rdy   = 1'b1;
        srdy      = 4'b0000;
        gen_mask  = 4'b0000;
        gen_prob  = 100;
        len_fixed = 3;
        len_max   = 4;
        src_inst  = 0;
        for (int p = 0; p < 4; p++) din[p] = '0;

        // Vector table: single-line packet, stall, upstream gap, clear mid-packet.
        tbl[0]  = '{1'b0, 4'b0001, 4'b0001, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000};
        tbl[1]  = '{1'b0, 4'b0011, 4'b0001, 1'b1, 1'b1, 2'd0, 1'b1, 4'b0001};
        tbl[2]  = '{1'b0, 4'b0010, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000};
        tbl[3]  = '{1'b0, 4'b0010, 4'b0000, 1'b1, 1'b1, 2'd1, 1'b1, 4'b0010};
        tbl[4]  = '{1'b0, 4'b0010, 4'b0010, 1'b0, 1'b1, 2'd1, 1'b1, 4'b0000};
        tbl[5]  = '{1'b0, 4'b0010, 4'b0010, 1'b1, 1'b1, 2'd1, 1'b1, 4'b0010};
        tbl[6]  = '{1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd1, 1'b0, 4'b0000};
        tbl[7]  = '{1'b0, 4'b1000, 4'b0000, 1'b1, 1'b0, 2'd1, 1'b0, 4'b0000};
        tbl[8]  = '{1'b0, 4'b1000, 4'b0000, 1'b1, 1'b1, 2'd3, 1'b1, 4'b1000};
        tbl[9]  = '{1'b1, 4'b1000, 4'b0000, 1'b1, 1'b1, 2'd3, 1'b1, 4'b1000};
        tbl[10] = '{1'b0, 4'b1000, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000};
        tbl[11] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd3, 1'b0, 4'b1000};

        do_reset();
        for (int i = 0; i < 12; i++) begin
            clear   = tbl[i].clr;
            srdy    = tbl[i].srdy;
            dst_rdy = tbl[i].dst;
            for (int p = 0; p < 4; p++) din[p] = {2'b00, tbl[i].eof[p], 1'b0, 32'hA000_0000 | p};
            @(negedge clk);
            chk($sformatf("tbl%0d_busy", i), 36'(bsy[0]), 36'(tbl[i].busy));
            chk($sformatf("tbl%0d_grant", i), 36'(gnt[0]), 36'(tbl[i].grant));
            chk($sformatf("tbl%0d_src_rdy", i), 36'(sro[0]), 36'(tbl[i].sro));
            chk($sformatf("tbl%0d_dst_rdy", i), 36'(dro[0]), 36'(tbl[i].dro));
            if (tbl[i].sro) chk($sformatf("tbl%0d_data", i), dout[0], din[tbl[i].grant]);
            @(posedge clk);
            model_update();
            #1;
        end
        clear = 1'b0;

        // All ports, 3-line packets: order 0,1,2,3 with one bubble between packets.
        do_reset();
        gen_mask = 4'hF; gen_prob = 100; len_fixed = 3; src_inst = 0;
        port_en = 4'hF; dst_rdy = 1'b1;
        gen_init();
        nlines = 0;
        order.delete();
        for (int c = 0; c < 16; c++) begin
            step(1'b1, 1'b1);
            chk($sformatf("t1_fire_c%0d", c), 36'(o_fire), 36'((c % 4) != 0));
            if (o_fire) begin
                nlines++;
                if (o_line[32]) order.push_back(int'(o_gnt));
            end
        end
        chk("t1_lines", 36'(nlines), 36'd12);
        chk("t1_pkts", 36'(order.size()), 36'd4);
        for (int i = 0; i < order.size() && i < 4; i++)
            chk($sformatf("t1_order%0d", i), 36'(order[i]), 36'(i));

        // Fixed priority: ports 1 and 3 always requesting, port 3 starved.
        do_reset();
        gen_mask = 4'b1010; len_fixed = 2; src_inst = 1;
        gen_init();
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            step(1'b1, 1'b1);
            if (o_fire && o_line[32]) begin
                seen++;
                chk("t2_grant", 36'(o_gnt), 36'd1);
            end
        end
        chk("t2_pkts", 36'(seen), 36'd10);

        // Port 2, 5 lines with dst_rdy toggling: lines in order, grant 2 throughout.
        do_reset();
        gen_mask = 4'b0100; len_fixed = 5; src_inst = 0;
        gen_init();
        nlines = 0;
        for (int c = 0; c < 40 && nlines < 5; c++) begin
            dst_rdy = c[0];
            step(1'b1, 1'b1);
            if (o_fire) begin
                chk("t3_seq", 36'(o_line[15:0]), 36'(nlines));
                chk("t3_grant", 36'(o_gnt), 36'd2);
                nlines++;
            end
        end
        chk("t3_lines", 36'(nlines), 36'd5);
        dst_rdy = 1'b1;

        // Port 1 enable dropped mid-packet: packet completes, port 1 not regranted.
        do_reset();
        gen_mask = 4'b0010; len_fixed = 6; src_inst = 0;
        port_en = 4'hF;
        gen_init();
        p1_lines = 0;
        for (int c = 0; c < 20 && p1_lines < 2; c++) begin
            step(1'b1, 1'b1);
            if (o_fire) p1_lines++;
        end
        port_en = 4'b1101;
        gen_mask = 4'b0011;
        drive_src();
        p1_done = 1'b0;
        regrant = 0;
        for (int c = 0; c < 30; c++) begin
            step(1'b1, 1'b1);
            if (o_fire && o_gnt == 2'd1) begin
                if (p1_done) regrant++;
                else p1_lines++;
                if (o_line[33]) p1_done = 1'b1;
            end
        end
        chk("t5_p1_lines", 36'(p1_lines), 36'd6);
        chk("t5_regrant", 36'(regrant), 36'd0);
        port_en = 4'hF;

        // Random traffic against the model on both instances.
        do_reset();
        gen_mask = 4'hF; gen_prob = 70; len_fixed = 0; len_max = 4; src_inst = 0;
        gen_init();
        for (int c = 0; c < 3000; c++) begin
            if (c % 50 == 0) port_en = 4'($urandom_range(15));
            dst_rdy = ($urandom_range(3) != 0);
            clear   = ($urandom_range(199) == 0);
            step(1'b1, 1'b1);
        end
        clear = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
